main_sched: RTL and testbench

Two-requester scheduler for the shared `main` processing unit (8-bit `x` in, `y`/`s`/`b` out, mode select `on`, `start` strobe, `active` status). Requesters submit a mode plus an 8-bit operand. The scheduler arbitrates round-robin, sequences `on`/`start`/`x` into the unit, and waits for the unit's `active` pulse to complete. It returns the captured result with a one-cycle ack and guards against hangs with a timeout.

---
 rtl/main_sched_pkg.sv | 28 ++
 rtl/main_sched_rr_arb2.sv | 19 +
 rtl/main_sched.sv | 160 ++++++++++++++++
 tb/tb_main_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/main_sched_pkg.sv
// Shared types and constants for the two-requester scheduler of the main unit.
package main_sched_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } state_t;

    // Unit regime that leaves the processing unit switched off.
    localparam logic [1:0] MODE_OFF = 2'b00;

    typedef struct packed {
        logic [7:0] y;
        logic [2:0] s;
        logic       b;
    } result_t;

    localparam result_t RESULT_ZERO = {8'h00, 3'b000, 1'b0};

    // Pointer value that favours the requester that was not just served.
    function automatic logic other_ptr(input logic [1:0] served);
        return served[0];
    endfunction

endpackage

// File: rtl/main_sched_rr_arb2.sv
// Two-way round-robin pick: the pointer breaks ties, a lone candidate always wins.
module rr_arb2 (
    input  logic [1:0] cand,
    input  logic       ptr,
    output logic [1:0] win
);

    // One-hot winner from the candidate set and the preferred index.
    always_comb begin
        win = 2'b00;
        case (cand)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = ptr ? 2'b10 : 2'b01;
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/main_sched.sv
// Round-robin scheduler sequencing jobs from two requesters into the main unit.
module main_sched #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] mode0,
    input  logic [1:0] mode1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] gnt,
    output logic [1:0] ack,
    output logic       err,
    output logic [7:0] res_y,
    output logic [2:0] res_s,
    output logic       res_b,
    output logic       busy,
    output logic [1:0] unit_on,
    output logic       unit_start,
    output logic [7:0] unit_x,
    input  logic       unit_active,
    input  logic [7:0] unit_y,
    input  logic [2:0] unit_s,
    input  logic       unit_b
);
    import main_sched_pkg::*;

    localparam int              CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 32'sd1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(32'sd1);

    state_t        state_r;
    logic          ptr_r;
    logic [1:0]    mask_r;
    logic [CW-1:0] cnt_r;
    result_t       res_r;

    logic [1:0]    cand_s;
    logic [1:0]    win_s;
    logic [1:0]    sel_mode_s;
    logic [7:0]    sel_data_s;
    logic          done_ok_s;
    logic          tmo_s;

    // The requester served last sits out the first IDLE cycle after DONE.
    assign cand_s = req & ~mask_r;

    rr_arb2 u_arb (
        .cand (cand_s),
        .ptr  (ptr_r),
        .win  (win_s)
    );

    // Route the winner's regime and operand toward the launch registers.
    always_comb begin
        sel_mode_s = MODE_OFF;
        sel_data_s = 8'h00;
        if (win_s[1]) begin
            sel_mode_s = mode1;
            sel_data_s = data1;
        end else begin
            sel_mode_s = mode0;
            sel_data_s = data0;
        end
    end

    // Completion is the falling edge of active seen in WAIT; it beats a same-cycle timeout.
    assign done_ok_s = (state_r == WAIT) && !unit_active;
    assign tmo_s     = ((state_r == RUN) || (state_r == WAIT)) && (cnt_r == CNT_LAST) && !done_ok_s;

    assign res_y = res_r.y;
    assign res_s = res_r.s;
    assign res_b = res_r.b;

    // Scheduler FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            ptr_r      <= 1'b0;
            mask_r     <= 2'b00;
            cnt_r      <= {CW{1'b0}};
            res_r      <= RESULT_ZERO;
            gnt        <= 2'b00;
            ack        <= 2'b00;
            err        <= 1'b0;
            busy       <= 1'b0;
            unit_on    <= MODE_OFF;
            unit_start <= 1'b0;
            unit_x     <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    mask_r <= 2'b00;
                    if (win_s != 2'b00) begin
                        gnt  <= win_s;
                        busy <= 1'b1;
                        if (sel_mode_s == MODE_OFF) begin
                            // Illegal regime: answer at once, never touch the unit.
                            state_r <= DONE;
                            ack     <= win_s;
                            err     <= 1'b1;
                            res_r   <= RESULT_ZERO;
                        end else begin
                            state_r    <= LOAD;
                            unit_on    <= sel_mode_s;
                            unit_x     <= sel_data_s;
                            unit_start <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    unit_start <= 1'b0;
                    cnt_r      <= {CW{1'b0}};
                    state_r    <= RUN;
                end
                RUN, WAIT: begin
                    if (done_ok_s) begin
                        res_r   <= {unit_y, unit_s, unit_b};
                        err     <= 1'b0;
                        ack     <= gnt;
                        unit_on <= MODE_OFF;
                        state_r <= DONE;
                    end else if (tmo_s) begin
                        res_r   <= RESULT_ZERO;
                        err     <= 1'b1;
                        ack     <= gnt;
                        unit_on <= MODE_OFF;
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                        if ((state_r == RUN) && unit_active) begin
                            state_r <= WAIT;
                        end
                    end
                end
                DONE: begin
                    ack     <= 2'b00;
                    err     <= 1'b0;
                    gnt     <= 2'b00;
                    busy    <= 1'b0;
                    ptr_r   <= other_ptr(gnt);
                    mask_r  <= gnt;
                    state_r <= IDLE;
                end
                default: begin
                    state_r    <= IDLE;
                    mask_r     <= 2'b00;
                    gnt        <= 2'b00;
                    ack        <= 2'b00;
                    err        <= 1'b0;
                    busy       <= 1'b0;
                    unit_on    <= MODE_OFF;
                    unit_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_sched.sv
// Self-checking bench for main_sched: vector table, random jobs against an
// arithmetic latency/error model, and hand sequences for contention and reset.
module tb_main_sched;

    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] mode0 = 2'b00, mode1 = 2'b00;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic [1:0] gnt, ack, unit_on;
    logic       err, res_b, busy, unit_start;
    logic [7:0] res_y, unit_x;
    logic [2:0] res_s;
    logic       unit_active = 1'b0;
    logic [7:0] unit_y = 8'h00;
    logic [2:0] unit_s = 3'd0;
    logic       unit_b = 1'b0;

    int tests = 0;
    int fails = 0;

    // Stub behaviour: active high during cycles d..d+h-1 after the start cycle,
    // results valid only in the completion cycle d+h.
    int         st_d = 99, st_h = 1, st_k = 0;
    bit         st_v = 1'b0;
    logic [7:0] st_y = 8'h00;
    logic [2:0] st_s = 3'd0;
    logic       st_b = 1'b0;

    main_sched #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .req(req),
        .mode0(mode0), .mode1(mode1), .data0(data0), .data1(data1),
        .gnt(gnt), .ack(ack), .err(err),
        .res_y(res_y), .res_s(res_s), .res_b(res_b), .busy(busy),
        .unit_on(unit_on), .unit_start(unit_start), .unit_x(unit_x),
        .unit_active(unit_active), .unit_y(unit_y), .unit_s(unit_s), .unit_b(unit_b)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) st_v = 1'b0;
            else if (unit_start) begin st_v = 1'b1; st_k = 0; end
            else if (st_v && st_k < 1000) st_k++;
            unit_active = st_v && (st_k >= st_d) && (st_k < st_d + st_h);
            if (st_v && st_k == st_d + st_h) begin
                unit_y = st_y; unit_s = st_s; unit_b = st_b;
            end else begin
                unit_y = ~st_y; unit_s = ~st_s; unit_b = ~st_b;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: ack latency counted from the IDLE sampling cycle and error flag.
    function automatic void model(input logic [1:0] m, input int d, input int h,
                                  output logic e, output int lat);
        if (m == 2'b00) begin e = 1'b1; lat = 1; end
        else if (d + h > T) begin e = 1'b1; lat = 2 + T; end
        else begin e = 1'b0; lat = 2 + d + h; end
    endfunction

    task automatic run_job(input int idx, input logic [1:0] m, input logic [7:0] dat,
                           input int d, input int h, input logic [7:0] y, input logic [2:0] s,
                           input logic b, input logic exp_err, input int exp_lat);
        int cyc, starts, bad_gnt;
        logic [7:0] sx;
        logic [1:0] son, on_or, oh;
        bit got;
        oh = (idx == 1) ? 2'b10 : 2'b01;
        st_d = d; st_h = h; st_y = y; st_s = s; st_b = b;
        if (idx == 1) begin mode1 = m; data1 = dat; end
        else begin mode0 = m; data0 = dat; end
        req = oh;
        cyc = 0; starts = 0; bad_gnt = 0; sx = 8'h00; son = 2'b00; on_or = 2'b00; got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            on_or |= unit_on;
            if (unit_start) begin starts++; sx = unit_x; son = unit_on; end
            if (gnt !== oh) bad_gnt++;
            if (ack !== 2'b00) begin
                got = 1'b1;
                check("ack_vec", ack, oh);
                check("latency", cyc, exp_lat);
                check("err", err, exp_err);
                check("unit_on_at_ack", unit_on, 32'd0);
                if (m != 2'b00) begin
                    check("res_y", res_y, exp_err ? 32'd0 : {24'd0, y});
                    check("res_s", res_s, exp_err ? 32'd0 : {29'd0, s});
                    check("res_b", res_b, exp_err ? 32'd0 : {31'd0, b});
                end
            end
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL ack_wait: no ack within 40 cycles, required latency %0d", exp_lat);
        end
        req = 2'b00;
        check("start_pulses", starts, (m == 2'b00) ? 32'd0 : 32'd1);
        if (m != 2'b00) begin
            check("start_x", sx, dat);
            check("start_on", son, m);
        end else begin
            check("unit_untouched", on_or, 32'd0);
        end
        check("gnt_held", bad_gnt, 32'd0);
        @(negedge clk);
        check("busy_after", busy, 32'd0);
        check("gnt_after", gnt, 32'd0);
        check("ack_after", ack, 32'd0);
        @(negedge clk);
    endtask

    typedef struct {
        int         idx;
        logic [1:0] m;
        logic [7:0] dat;
        int         d;
        int         h;
        logic [7:0] y;
        logic [2:0] s;
        logic       b;
        logic       err;
        int         lat;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int cyc, n_ack, n_st, seen, extra_acks;
        logic [1:0] ack_v[3], gnt_v[3];
        logic [7:0] st_x[3];
        int ack_c[3], st_c[3];
        logic e;
        int lat, ri, rd, rh;
        logic [1:0] rm;

        tbl[0] = '{0, 2'b10, 8'h96, 2, 5, 8'h69, 3'd5, 1'b1, 1'b0, 9};   // single legal job
        tbl[1] = '{1, 2'b00, 8'h5A, 2, 2, 8'h11, 3'd1, 1'b0, 1'b1, 1};   // illegal regime
        tbl[2] = '{0, 2'b01, 8'h11, 99, 1, 8'h22, 3'd2, 1'b1, 1'b1, 10}; // unit never active
        tbl[3] = '{1, 2'b11, 8'hC3, 1, 1, 8'h3E, 3'd2, 1'b0, 1'b0, 4};   // minimum latency after timeout
        tbl[4] = '{0, 2'b10, 8'h44, 2, 6, 8'hA5, 3'd7, 1'b1, 1'b0, 10};  // completion on the timeout cycle
        tbl[5] = '{1, 2'b01, 8'h81, 3, 6, 8'h7E, 3'd3, 1'b1, 1'b1, 10};  // one cycle too slow
        tbl[6] = '{1, 2'b11, 8'h0F, 1, 7, 8'h5C, 3'd1, 1'b0, 1'b0, 10};  // exactly at the limit

        @(negedge clk);
        @(negedge clk);
        check("rst_gnt", gnt, 32'd0);
        check("rst_ack", ack, 32'd0);
        check("rst_err_res", {err, res_y, res_s, res_b}, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_unit", {unit_on, unit_start, unit_x}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_job(tbl[i].idx, tbl[i].m, tbl[i].dat, tbl[i].d, tbl[i].h,
                    tbl[i].y, tbl[i].s, tbl[i].b, tbl[i].err, tbl[i].lat);
        end

        for (int i = 0; i < 30; i++) begin
            ri = int'($urandom_range(0, 1));
            rm = 2'($urandom_range(0, 3));
            rd = ($urandom_range(0, 7) == 0) ? 99 : int'($urandom_range(1, 4));
            rh = int'($urandom_range(1, 6));
            model(rm, rd, rh, e, lat);
            run_job(ri, rm, 8'($urandom), rd, rh, 8'($urandom), 3'($urandom), 1'($urandom), e, lat);
        end

        // Leave the pointer on requester 1, so reset must bring it back to 0.
        run_job(0, 2'b01, 8'hA0, 1, 1, 8'h01, 3'd1, 1'b1, 1'b0, 4);

        // Contention from the first cycle after reset.
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mode0 = 2'b01; data0 = 8'h3C; mode1 = 2'b11; data1 = 8'h1A;
        st_d = 1; st_h = 1; st_y = 8'h42; st_s = 3'd4; st_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ack_v[i] = 2'b00; gnt_v[i] = 2'b00; st_x[i] = 8'h00; ack_c[i] = 0; st_c[i] = 0;
        end
        req = 2'b11;
        n_ack = 0; n_st = 0; cyc = 0;
        while (n_ack < 3 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (unit_start && n_st < 3) begin st_x[n_st] = unit_x; st_c[n_st] = cyc; n_st++; end
            if (ack != 2'b00 && n_ack < 3) begin
                ack_v[n_ack] = ack; gnt_v[n_ack] = gnt; ack_c[n_ack] = cyc; n_ack++;
                if (ack[1]) req[1] = 1'b0;
            end
        end
        req = 2'b00;
        check("cont_ack_count", n_ack, 32'd3);
        check("cont_start_count", n_st, 32'd3);
        check("cont_ack0", ack_v[0], 32'd1);
        check("cont_ack1", ack_v[1], 32'd2);
        check("cont_ack2", ack_v[2], 32'd1);
        check("cont_gnt0", gnt_v[0], 32'd1);
        check("cont_gnt1", gnt_v[1], 32'd2);
        check("cont_x0", st_x[0], 32'h3C);
        check("cont_x1", st_x[1], 32'h1A);
        check("cont_x2", st_x[2], 32'h3C);
        check("cont_gap1", st_c[1] - ack_c[0], 32'd2);
        check("cont_gap2", st_c[2] - ack_c[1], 32'd2);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);

        // Reset pulse while the unit reports active in WAIT.
        st_d = 1; st_h = 6; mode0 = 2'b01; data0 = 8'h77;
        req = 2'b01;
        seen = 0; cyc = 0;
        while (seen < 2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (unit_active) seen++;
        end
        check("mid_reached_wait", seen, 32'd2);
        check("mid_busy_before", busy, 32'd1);
        rst = 1'b1;
        req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        check("mid_unit_on", unit_on, 32'd0);
        check("mid_busy", busy, 32'd0);
        check("mid_gnt", gnt, 32'd0);
        extra_acks = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ack != 2'b00) extra_acks++;
        end
        check("mid_no_ack", extra_acks, 32'd0);

        run_job(1, 2'b10, 8'hE7, 2, 3, 8'h9D, 3'd6, 1'b1, 1'b0, 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
